// File: rtl/gate_tt_checker_if.sv
// Two-input gate bank bus: checker drives a_o/b_o, bank returns its six gate results.
interface gate_tt_checker_if;
    logic a_o;
    logic b_o;
    logic and_i;
    logic or_i;
    logic nota_i;
    logic notb_i;
    logic nand_i;
    logic nor_i;

    modport master (
        output a_o, b_o,
        input  and_i, or_i, nota_i, notb_i, nand_i, nor_i
    );

    modport slave (
        input  a_o, b_o,
        output and_i, or_i, nota_i, notb_i, nand_i, nor_i
    );
endinterface

// File: rtl/gate_tt_checker.sv
// Sweeps the gate bank through all four (a,b) vectors and checks its six outputs.
// Optional first-mismatch capture ports are enabled by defining GATE_TT_FIRST_FAIL_EN.
module gate_tt_checker #(
    parameter int SETTLE_CYC = 2,
    parameter int SETTLE_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    gate_tt_checker_if.master    bank,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [5:0]           err_mask,
`ifdef GATE_TT_FIRST_FAIL_EN
    output logic                 fail_vld,
    output logic [1:0]           fail_vec,
    output logic [5:0]           fail_obs,
`endif
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [SETTLE_W-1:0] LAST_CNT = SETTLE_W'(SETTLE_CYC - 1);

    state_t              state, state_n;
    logic [1:0]          vec, vec_n;
    logic [SETTLE_W-1:0] cnt, cnt_n;
    logic                busy_n, done_n, pass_n;
    logic [5:0]          err_n;
    logic [5:0]          obs, expd, mism;

    // The drive pins are the vector index itself, so they stay registered.
    assign bank.a_o  = vec[1];
    assign bank.b_o  = vec[0];
    assign dbg_state = state;

    assign obs  = {bank.nor_i, bank.nand_i, bank.notb_i, bank.nota_i, bank.or_i, bank.and_i};
    assign expd = {~(vec[1] | vec[0]), ~(vec[1] & vec[0]), ~vec[0], ~vec[1],
                   vec[1] | vec[0], vec[1] & vec[0]};
    assign mism = obs ^ expd;

`ifdef GATE_TT_FIRST_FAIL_EN
    logic       fail_vld_n;
    logic [1:0] fail_vec_n;
    logic [5:0] fail_obs_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_mask <= '0;
`ifdef GATE_TT_FIRST_FAIL_EN
            fail_vld <= 1'b0;
            fail_vec <= '0;
            fail_obs <= '0;
`endif
        end else begin
            state    <= state_n;
            vec      <= vec_n;
            cnt      <= cnt_n;
            busy     <= busy_n;
            done     <= done_n;
            pass     <= pass_n;
            err_mask <= err_n;
`ifdef GATE_TT_FIRST_FAIL_EN
            fail_vld <= fail_vld_n;
            fail_vec <= fail_vec_n;
            fail_obs <= fail_obs_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        vec_n   = vec;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        err_n   = err_mask;
`ifdef GATE_TT_FIRST_FAIL_EN
        fail_vld_n = fail_vld;
        fail_vec_n = fail_vec;
        fail_obs_n = fail_obs;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SETTLE;
                    vec_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    err_n   = '0;
`ifdef GATE_TT_FIRST_FAIL_EN
                    fail_vld_n = 1'b0;
                    fail_vec_n = '0;
                    fail_obs_n = '0;
`endif
                end
            end
            SETTLE: begin
                if (cnt == LAST_CNT) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt + SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                err_n = err_mask | mism;
`ifdef GATE_TT_FIRST_FAIL_EN
                if ((mism != 6'd0) && !fail_vld) begin
                    fail_vld_n = 1'b1;
                    fail_vec_n = vec;
                    fail_obs_n = obs;
                end
`endif
                if (vec != 2'd3) begin
                    vec_n   = vec + 2'd1;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end else begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == 6'd0);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: faultable gate bank model, directed sweeps, result scoreboard.
module tb_gate_tt_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done, pass;
    logic [5:0] err_mask;
    logic [1:0] dbg_state;
`ifdef GATE_TT_FIRST_FAIL_EN
    logic       fail_vld;
    logic [1:0] fail_vec;
    logic [5:0] fail_obs;
`endif

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q[$];

    gate_tt_checker_if bank ();

    gate_tt_checker #(.SETTLE_CYC(2), .SETTLE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bank      (bank),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_mask  (err_mask),
`ifdef GATE_TT_FIRST_FAIL_EN
        .fail_vld  (fail_vld),
        .fail_vec  (fail_vec),
        .fail_obs  (fail_obs),
`endif
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gate bank model with per-output stuck-at injection
    logic [5:0] ideal, obs, f_mask, f_val;
    logic       ma, mb;
    assign ma = bank.a_o;
    assign mb = bank.b_o;
    assign ideal = {~(ma | mb), ~(ma & mb), ~mb, ~ma, ma | mb, ma & mb};
    assign obs   = (ideal & ~f_mask) | (f_val & f_mask);
    assign bank.and_i  = obs[0];
    assign bank.or_i   = obs[1];
    assign bank.nota_i = obs[2];
    assign bank.notb_i = obs[3];
    assign bank.nand_i = obs[4];
    assign bank.nor_i  = obs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass}, 32'd0);
        check({tag, "_err"}, {26'd0, err_mask}, 32'd0);
        check({tag, "_ab"}, {30'd0, bank.a_o, bank.b_o}, 32'd0);
        check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    // scoreboard monitor: one {pass,err_mask} result per rising done
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                check("sweep_result", {25'd0, pass, err_mask}, {25'd0, e});
            end
        end
        done_q <= done;
    end

    // one sweep; abort_at / repulse_at are negedge indices after the start edge (-1 = unused)
    task automatic run_sweep(input logic [5:0] fm, input logic [5:0] fv, input logic [6:0] expv,
                             input int repulse_at, input int abort_at);
        int n;
        bit fin;
        f_mask = fm;
        f_val  = fv;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        check("start_done_clr", {31'd0, done}, 32'd0);
        check("start_err_clr", {26'd0, err_mask}, 32'd0);
        check("start_busy", {31'd0, busy}, 32'd1);
        fin = 1'b0;
        while (!fin) begin
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                fin = 1'b1;
            end else if (done) begin
                check("done_edge", n, 32'd12);
                check("busy_off", {31'd0, busy}, 32'd0);
                fin = 1'b1;
            end else if (n >= 40) begin
                check("done_timeout", n, 32'd12);
                exp_q.delete();
                fin = 1'b1;
            end else begin
                if ((n % 3) == 1 && n < 12)
                    check("vector_ab", {30'd0, bank.a_o, bank.b_o}, n / 3);
                start = (n == repulse_at);
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
    endtask

`ifdef GATE_TT_FIRST_FAIL_EN
    task automatic check_first_fail(input logic v, input logic [1:0] fv, input logic [5:0] fo);
        check("fail_vld", {31'd0, fail_vld}, {31'd0, v});
        check("fail_vec", {30'd0, fail_vec}, {30'd0, fv});
        check("fail_obs", {26'd0, fail_obs}, {26'd0, fo});
    endtask
`endif

    // driver
    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        f_mask = '0;
        f_val  = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // ideal bank
        run_sweep(6'b000000, 6'b000000, {1'b1, 6'b000000}, -1, -1);
`ifdef GATE_TT_FIRST_FAIL_EN
        check_first_fail(1'b0, 2'd0, 6'd0);
`endif
        // start re-pulsed during vector 1 is ignored
        run_sweep(6'b000000, 6'b000000, {1'b1, 6'b000000}, 4, -1);
        // nand stuck at 0
        run_sweep(6'b010000, 6'b000000, {1'b0, 6'b010000}, -1, -1);
        // restart from failing DONE with a good bank
        run_sweep(6'b000000, 6'b000000, {1'b1, 6'b000000}, -1, -1);
        // and stuck at 1: wrong for vectors 00,01,10
        run_sweep(6'b000001, 6'b000001, {1'b0, 6'b000001}, -1, -1);
`ifdef GATE_TT_FIRST_FAIL_EN
        check_first_fail(1'b1, 2'd0, 6'b111101);
`endif
        // nor stuck at 1: wrong for vectors 01,10,11
        run_sweep(6'b100000, 6'b100000, {1'b0, 6'b100000}, -1, -1);
`ifdef GATE_TT_FIRST_FAIL_EN
        check_first_fail(1'b1, 2'd1, 6'b110110);
`endif
        // reset during vector 2 settle, with a failing bank so err_mask is non-zero
        run_sweep(6'b010000, 6'b000000, 7'd0, -1, 7);
        check_idle_outputs("after_abort");
        // normal sweep after abort
        run_sweep(6'b000000, 6'b000000, {1'b1, 6'b000000}, -1, -1);
`ifdef GATE_TT_FIRST_FAIL_EN
        check_first_fail(1'b0, 2'd0, 6'd0);
`endif
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
